// File: rtl/uncache_wbuf.sv
// uncache_wbuf: uncached data-access unit with a posted write buffer.
// Uncached stores are queued in a small FIFO and retire without stalling.
// Uncached loads wait until the FIFO has fully drained, so device accesses
// reach the bus in program order. Only one bus transaction is active at a time.
`timescale 1ns/1ps

module uncache_wbuf #(
    parameter int WB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,

    // AXI-side request interface (shared protocol with the data cache)
    input  logic        AXI_rd_dready,
    input  logic        AXI_rd_last,
    input  logic [31:0] AXI_rd_data,
    input  logic        AXI_rd_addr_clear,
    input  logic        AXI_wr_next,
    input  logic        AXI_wr_ok,
    input  logic        AXI_wr_addr_clear,
    output logic [31:0] AXI_addr,
    output logic        AXI_addr_valid,
    output logic        AXI_we,
    output logic [2:0]  AXI_size,
    output logic [7:0]  AXI_lens,
    output logic        AXI_rd_rready,
    output logic [31:0] AXI_wr_data,
    output logic        AXI_wr_dready,
    output logic [3:0]  AXI_byte_enable,
    output logic        AXI_wr_last,
    output logic        AXI_response_rready,

    // CPU-side uncached access port
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_byteenable,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_wrdata,
    input  logic        cpu_new_ins,
    output logic [31:0] cpu_rddata,
    output logic        cpu_stall,
    output logic        wb_empty
);

    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = WB_DEPTH[PTR_W:0];

    // Bus FSM encoding
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_W_ADDR = 3'd1;
    localparam logic [2:0] S_W_DATA = 3'd2;
    localparam logic [2:0] S_W_RESP = 3'd3;
    localparam logic [2:0] S_R_ADDR = 3'd4;
    localparam logic [2:0] S_R_DATA = 3'd5;
    localparam logic [2:0] S_R_DONE = 3'd6;

    // Write-buffer storage and bookkeeping
    logic [31:0]      wb_addr [WB_DEPTH];
    logic [3:0]       wb_be   [WB_DEPTH];
    logic [31:0]      wb_data [WB_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic             consumed;
    logic [31:0]      rd_data;

    logic             req_live;
    logic             store_req;
    logic             load_req;
    logic             push;
    logic             pop;
    logic             load_done;
    logic [31:0]      head_addr;
    logic [3:0]       head_be;
    logic [31:0]      head_data;

    // Byte-enable pattern to transfer size: word, halfword, otherwise byte.
    function automatic logic [2:0] size_of(input logic [3:0] be);
        case (be)
            4'b1111:          size_of = 3'd2;
            4'b0011, 4'b1100: size_of = 3'd1;
            default:          size_of = 3'd0;
        endcase
    endfunction

    // A request is only acted on once per instruction: after a store is
    // queued or a load returns, the same request is ignored until the
    // pipeline advances. A set flag is overridden by cpu_new_ins in the
    // same cycle, so back-to-back instructions are not lost.
    assign req_live  = !(consumed && !cpu_new_ins);
    // Both read and write high is treated as a write.
    assign store_req = cpu_write && req_live;
    assign load_req  = cpu_read && !cpu_write && req_live;
    assign push      = store_req && (count < FULL_COUNT);
    assign pop       = (state == S_W_RESP) && AXI_wr_ok;
    assign load_done = (state == S_R_DONE);

    assign head_addr = wb_addr[rd_ptr];
    assign head_be   = wb_be[rd_ptr];
    assign head_data = wb_data[rd_ptr];

    // Stall while a store waits for a free slot or a load is outstanding;
    // the load releases the pipeline in R_DONE, when its data is valid.
    assign cpu_stall = !rst && ((store_req && !push) || (load_req && !load_done));

    assign wb_empty    = (state == S_IDLE) && (count == '0);
    assign cpu_rddata  = rd_data;
    assign AXI_lens    = 8'd0;
    assign AXI_wr_last = AXI_wr_dready;

    // Next-state logic: draining the buffer always wins over a pending load.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        state_next = state;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    state_next = S_W_ADDR;
                end else if (load_req) begin
                    state_next = S_R_ADDR;
                end
            end
            S_W_ADDR: if (AXI_wr_addr_clear)               state_next = S_W_DATA;
            S_W_DATA: if (AXI_wr_next)                     state_next = S_W_RESP;
            S_W_RESP: if (AXI_wr_ok)                       state_next = S_IDLE;
            S_R_ADDR: if (AXI_rd_addr_clear)               state_next = S_R_DATA;
            S_R_DATA: if (AXI_rd_dready && AXI_rd_last)    state_next = S_R_DONE;
            S_R_DONE:                                      state_next = S_IDLE;
            default:                                       state_next = S_IDLE;
        endcase
    end

    // Bus request outputs: head entry for writes, CPU request for reads.
    always_comb begin
        AXI_addr            = '0;
        AXI_size            = '0;
        AXI_byte_enable     = '0;
        AXI_wr_data         = '0;
        AXI_addr_valid      = 1'b0;
        AXI_we              = 1'b0;
        AXI_rd_rready       = 1'b0;
        AXI_wr_dready       = 1'b0;
        AXI_response_rready = 1'b0;
        case (state)
            S_W_ADDR, S_W_DATA, S_W_RESP: begin
                AXI_addr        = head_addr;
                AXI_size        = size_of(head_be);
                AXI_byte_enable = head_be;
                AXI_wr_data     = head_data;
                AXI_we          = 1'b1;
            end
            S_R_ADDR, S_R_DATA, S_R_DONE: begin
                AXI_addr        = cpu_addr;
                AXI_size        = size_of(cpu_byteenable);
                AXI_byte_enable = cpu_byteenable;
            end
            default: ;
        endcase
        case (state)
            S_W_ADDR: AXI_addr_valid      = 1'b1;
            S_W_DATA: AXI_wr_dready       = 1'b1;
            S_W_RESP: AXI_response_rready = 1'b1;
            S_R_ADDR: AXI_addr_valid      = 1'b1;
            S_R_DATA: AXI_rd_rready       = 1'b1;
            default: ;
        endcase
    end

    // FSM state and captured load data.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state   <= S_IDLE;
            rd_data <= '0;
        end else begin
            state <= state_next;
            if (state == S_R_DATA && AXI_rd_dready && AXI_rd_last) begin
                rd_data <= AXI_rd_data;
            end
        end
    end

    // Buffer pointers and occupancy; push and pop together leave count alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Buffer payload storage.
    always_ff @(posedge clk) begin
        // NOTE: the payload array has no reset; an entry is only read after
        // being written, and count/pointers alone define what is valid.
        if (push) begin
            wb_addr[wr_ptr] <= cpu_addr;
            wb_be[wr_ptr]   <= cpu_byteenable;
            wb_data[wr_ptr] <= cpu_wrdata;
        end
    end

    // Once-per-instruction flag for CPU requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            consumed <= 1'b0;
        end else if (push || load_done) begin
            consumed <= 1'b1;
        end else if (cpu_new_ins) begin
            consumed <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uncache_wbuf.sv
// Self-checking bench for uncache_wbuf: a responsive bus model on the AXI
// side, scoreboards of expected bus writes and load results, and one task
// per scenario.
`timescale 1ns/1ps

module tb_uncache_wbuf;

    localparam int WB_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        AXI_rd_dready, AXI_rd_last, AXI_rd_addr_clear;
    logic [31:0] AXI_rd_data;
    logic        AXI_wr_next, AXI_wr_ok, AXI_wr_addr_clear;
    logic [31:0] AXI_addr;
    logic        AXI_addr_valid, AXI_we;
    logic [2:0]  AXI_size;
    logic [7:0]  AXI_lens;
    logic        AXI_rd_rready;
    logic [31:0] AXI_wr_data;
    logic        AXI_wr_dready;
    logic [3:0]  AXI_byte_enable;
    logic        AXI_wr_last, AXI_response_rready;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_byteenable;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_wrdata;
    logic        cpu_new_ins;
    logic [31:0] cpu_rddata;
    logic        cpu_stall;
    logic        wb_empty;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [2:0]  size;
    } wr_exp_t;

    wr_exp_t     exp_wr_q[$];
    logic [31:0] exp_rd_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_writes = 0;
    int first_ok_cyc = -1;
    int last_ok_cyc = -1;
    int first_rd_cyc = -1;
    bit hold_wr_ok = 1'b0;
    bit hold_wr_next = 1'b0;
    logic [31:0] rd_word = 32'h0;

    uncache_wbuf #(.WB_DEPTH(WB_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .AXI_rd_dready(AXI_rd_dready), .AXI_rd_last(AXI_rd_last),
        .AXI_rd_data(AXI_rd_data), .AXI_rd_addr_clear(AXI_rd_addr_clear),
        .AXI_wr_next(AXI_wr_next), .AXI_wr_ok(AXI_wr_ok),
        .AXI_wr_addr_clear(AXI_wr_addr_clear),
        .AXI_addr(AXI_addr), .AXI_addr_valid(AXI_addr_valid), .AXI_we(AXI_we),
        .AXI_size(AXI_size), .AXI_lens(AXI_lens), .AXI_rd_rready(AXI_rd_rready),
        .AXI_wr_data(AXI_wr_data), .AXI_wr_dready(AXI_wr_dready),
        .AXI_byte_enable(AXI_byte_enable), .AXI_wr_last(AXI_wr_last),
        .AXI_response_rready(AXI_response_rready),
        .cpu_addr(cpu_addr), .cpu_byteenable(cpu_byteenable),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_wrdata(cpu_wrdata),
        .cpu_new_ins(cpu_new_ins), .cpu_rddata(cpu_rddata),
        .cpu_stall(cpu_stall), .wb_empty(wb_empty)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] exp_size(input logic [3:0] be);
        if (be == 4'b1111)                         return 3'd2;
        else if (be == 4'b0011 || be == 4'b1100)   return 3'd1;
        else                                       return 3'd0;
    endfunction

    // Bus model: answers each phase one cycle after it is requested and
    // checks every accepted write beat against the expected-write queue.
    initial begin
        AXI_rd_dready = 0; AXI_rd_last = 0; AXI_rd_data = '0; AXI_rd_addr_clear = 0;
        AXI_wr_next = 0; AXI_wr_ok = 0; AXI_wr_addr_clear = 0;
        forever begin
            @(negedge clk);
            AXI_wr_addr_clear = AXI_addr_valid && AXI_we;
            AXI_rd_addr_clear = AXI_addr_valid && !AXI_we;
            AXI_wr_next       = AXI_wr_dready && !hold_wr_next;
            AXI_wr_ok         = AXI_response_rready && !hold_wr_ok;
            AXI_rd_dready     = AXI_rd_rready;
            AXI_rd_last       = AXI_rd_rready;
            AXI_rd_data       = AXI_rd_rready ? rd_word : 32'h0;
            if (AXI_wr_ok) begin
                last_ok_cyc = cyc;
                if (first_ok_cyc < 0) first_ok_cyc = cyc;
            end
            if (AXI_addr_valid && !AXI_we && first_rd_cyc < 0) first_rd_cyc = cyc;
            if (AXI_wr_next) begin
                wr_exp_t e;
                n_writes++;
                tests++;
                if (exp_wr_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_write: got addr=%h data=%h be=%b, required none",
                             AXI_addr, AXI_wr_data, AXI_byte_enable);
                end else begin
                    e = exp_wr_q.pop_front();
                    if (AXI_addr !== e.addr || AXI_wr_data !== e.data ||
                        AXI_byte_enable !== e.be || AXI_size !== e.size ||
                        AXI_lens !== 8'd0 || AXI_wr_last !== 1'b1) begin
                        fails++;
                        $display("[TB] FAIL write_beat: got addr=%h data=%h be=%b size=%0d lens=%0d last=%b, required addr=%h data=%h be=%b size=%0d lens=0 last=1",
                                 AXI_addr, AXI_wr_data, AXI_byte_enable, AXI_size, AXI_lens,
                                 AXI_wr_last, e.addr, e.data, e.be, e.size);
                    end
                end
            end
        end
    end

    // Present a new store; hold it (as a frozen pipeline would) while stalled.
    task automatic issue_store(input logic [31:0] a, input logic [3:0] be,
                               input logic [31:0] d, output int stalls, output int push_cyc);
        stalls = 0;
        @(negedge clk);
        cpu_addr = a; cpu_byteenable = be; cpu_wrdata = d;
        cpu_write = 1'b1; cpu_read = 1'b0; cpu_new_ins = 1'b1;
        exp_wr_q.push_back('{addr: a, be: be, data: d, size: exp_size(be)});
        #1;
        while (cpu_stall && stalls < 500) begin
            @(negedge clk);
            cpu_new_ins = 1'b0;
            #1;
            stalls++;
        end
        if (cpu_stall) begin
            tests++; fails++;
            $display("[TB] FAIL store_timeout: stall still %b after %0d cycles, required 0", cpu_stall, stalls);
        end
        push_cyc = cyc;
        @(posedge clk); #1;
        cpu_new_ins = 1'b0;
    endtask

    // Present a new load, wait for release, and check the returned word.
    task automatic issue_load(input logic [31:0] a, input logic [3:0] be,
                              input logic [31:0] word, output int stalls);
        logic [31:0] e;
        stalls = 0;
        @(negedge clk);
        rd_word = word;
        exp_rd_q.push_back(word);
        cpu_addr = a; cpu_byteenable = be;
        cpu_read = 1'b1; cpu_write = 1'b0; cpu_new_ins = 1'b1;
        #1;
        while (cpu_stall && stalls < 500) begin
            @(negedge clk);
            cpu_new_ins = 1'b0;
            #1;
            stalls++;
        end
        e = exp_rd_q.pop_front();
        tests++;
        if (cpu_stall !== 1'b0 || cpu_rddata !== e) begin
            fails++;
            $display("[TB] FAIL load_data: got stall=%b rddata=%h, required stall=0 rddata=%h",
                     cpu_stall, cpu_rddata, e);
        end
        @(posedge clk); #1;
        cpu_new_ins = 1'b0;
    endtask

    task automatic cpu_quiet();
        @(negedge clk);
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_new_ins = 1'b1;
        @(negedge clk);
        cpu_new_ins = 1'b0;
    endtask

    // Wait (bounded) for the buffer and bus to go idle; all writes seen.
    task automatic wait_drain(input string name);
        int n = 0;
        @(negedge clk); #1;
        while (!wb_empty && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        tests++;
        if (wb_empty !== 1'b1 || exp_wr_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL %s_drain: got wb_empty=%b pending=%0d, required wb_empty=1 pending=0",
                     name, wb_empty, exp_wr_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_addr = '0; cpu_byteenable = '0; cpu_wrdata = '0;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_new_ins = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        tests++;
        if ({AXI_addr_valid, AXI_we, AXI_rd_rready, AXI_wr_dready, AXI_wr_last, AXI_response_rready} !== 6'b0) begin
            fails++;
            $display("[TB] FAIL reset_ctrl: got %b, required 000000",
                     {AXI_addr_valid, AXI_we, AXI_rd_rready, AXI_wr_dready, AXI_wr_last, AXI_response_rready});
        end
        tests++;
        if (AXI_addr !== 32'h0 || AXI_size !== 3'd0 || AXI_byte_enable !== 4'd0 || AXI_wr_data !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_bus: got addr=%h size=%0d be=%b data=%h, required all 0",
                     AXI_addr, AXI_size, AXI_byte_enable, AXI_wr_data);
        end
        tests++;
        if (cpu_rddata !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_rddata: got %h, required 0", cpu_rddata);
        end
        tests++;
        if (cpu_stall !== 1'b0 || wb_empty !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_status: got stall=%b wb_empty=%b, required 0/1", cpu_stall, wb_empty);
        end
    endtask

    task automatic test_posted_stores();
        int s, pc, total, base;
        total = 0;
        base = n_writes;
        for (int i = 0; i < 4; i++) begin
            issue_store(32'h1000_0000 + 32'(i * 4), 4'b1111, 32'hA000_0000 + 32'(i), s, pc);
            total += s;
        end
        cpu_quiet();
        tests++;
        if (total !== 0) begin
            fails++;
            $display("[TB] FAIL posted_stall: got %0d stall cycles, required 0", total);
        end
        wait_drain("posted");
        tests++;
        if (n_writes - base !== 4) begin
            fails++;
            $display("[TB] FAIL posted_count: got %0d writes, required 4", n_writes - base);
        end
    endtask

    task automatic test_byte_store();
        int s, pc, base;
        base = n_writes;
        issue_store(32'h1000_0022, 4'b0100, 32'h00AB_0000, s, pc);
        cpu_quiet();
        tests++;
        if (s !== 0) begin
            fails++;
            $display("[TB] FAIL byte_stall: got %0d stall cycles, required 0", s);
        end
        wait_drain("byte");
        tests++;
        if (n_writes - base !== 1) begin
            fails++;
            $display("[TB] FAIL byte_count: got %0d writes, required 1", n_writes - base);
        end
    endtask

    task automatic test_load_ordering();
        int s, pc;
        first_rd_cyc = -1;
        last_ok_cyc = -1;
        issue_store(32'h1000_0004, 4'b0011, 32'h0000_BEEF, s, pc);
        issue_load(32'h1000_0008, 4'b1111, 32'hCAFE_1234, s);
        tests++;
        if (last_ok_cyc < 0 || first_rd_cyc <= last_ok_cyc) begin
            fails++;
            $display("[TB] FAIL load_order: got read addr cycle %0d, write ok cycle %0d, required read after write ok",
                     first_rd_cyc, last_ok_cyc);
        end
        cpu_quiet();
        wait_drain("order");
    endtask

    task automatic test_load_latency_no_dup();
        int s, valid_seen, stall_seen, bad_data;
        issue_load(32'h1000_0010, 4'b1111, 32'h1357_9BDF, s);
        tests++;
        if (s !== 3) begin
            fails++;
            $display("[TB] FAIL load_latency: got %0d stall cycles, required 3", s);
        end
        valid_seen = 0; stall_seen = 0; bad_data = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cpu_read = 1'b1; cpu_new_ins = 1'b0;
            #1;
            if (AXI_addr_valid) valid_seen++;
            if (cpu_stall) stall_seen++;
            if (cpu_rddata !== 32'h1357_9BDF) bad_data++;
        end
        tests++;
        if (valid_seen !== 0 || stall_seen !== 0) begin
            fails++;
            $display("[TB] FAIL no_dup: got addr_valid cycles=%0d stall cycles=%0d, required 0/0",
                     valid_seen, stall_seen);
        end
        tests++;
        if (bad_data !== 0) begin
            fails++;
            $display("[TB] FAIL rddata_held: got %h (%0d bad cycles), required 13579bdf", cpu_rddata, bad_data);
        end
        cpu_quiet();
    endtask

    task automatic test_full_buffer();
        int s, pc, total, base, s5, pc5;
        total = 0;
        base = n_writes;
        first_ok_cyc = -1;
        hold_wr_ok = 1'b1;
        for (int i = 0; i < WB_DEPTH; i++) begin
            issue_store(32'h2000_0000 + 32'(i * 4), 4'b1111, 32'h5500_0000 + 32'(i), s, pc);
            total += s;
        end
        fork
            issue_store(32'h2000_0040, 4'b1100, 32'h7788_0000, s5, pc5);
            begin
                repeat (8) @(posedge clk);
                hold_wr_ok = 1'b0;
            end
        join
        cpu_quiet();
        tests++;
        if (total !== 0 || s5 == 0) begin
            fails++;
            $display("[TB] FAIL full_stall: got first stalls=%0d fifth stalls=%0d, required 0 and >0", total, s5);
        end
        tests++;
        if (first_ok_cyc < 0 || pc5 !== first_ok_cyc + 1) begin
            fails++;
            $display("[TB] FAIL full_enqueue: got enqueue cycle %0d, required %0d", pc5, first_ok_cyc + 1);
        end
        wait_drain("full");
        tests++;
        if (n_writes - base !== 5) begin
            fails++;
            $display("[TB] FAIL full_count: got %0d writes, required 5", n_writes - base);
        end
    endtask

    task automatic test_reset_mid_write();
        int s, pc, valid_seen;
        hold_wr_next = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue_store(32'h3000_0000 + 32'(i * 4), 4'b1111, 32'h6600_0000 + 32'(i), s, pc);
        end
        cpu_write = 1'b0;
        tests++;
        if (AXI_wr_dready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mid_precond: got wr_dready=%b, required 1", AXI_wr_dready);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        hold_wr_next = 1'b0;
        exp_wr_q.delete();
        #1;
        tests++;
        if (AXI_wr_dready !== 1'b0 || wb_empty !== 1'b1 || cpu_stall !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mid_reset: got wr_dready=%b wb_empty=%b stall=%b, required 0/1/0",
                     AXI_wr_dready, wb_empty, cpu_stall);
        end
        valid_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (AXI_addr_valid || !wb_empty) valid_seen++;
        end
        tests++;
        if (valid_seen !== 0) begin
            fails++;
            $display("[TB] FAIL mid_discard: got %0d busy cycles after reset, required 0", valid_seen);
        end
    endtask

    initial begin
        test_reset();
        test_posted_stores();
        test_byte_store();
        test_load_ordering();
        test_load_latency_no_dup();
        test_full_buffer();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
